// File: rtl/up_sample_if.sv
// up_sample_if: pixel-stream bundle for the up_sample block.
//
// Signals:
//   en_upsample - mode select (1: 2x upsample, 0: registered bypass)
//   data_in     - input pixel
//   valid_in    - data_in is valid this cycle
//   ready_in    - block can take a pixel this cycle
//   data_out    - output pixel
//   valid_out   - data_out is valid this cycle (no downstream backpressure)
//   row_done    - pulse with the last output pixel of each upsampled row pair
//
// Handshake: an input pixel transfers on a rising clk edge where
// valid_in && ready_in are both 1. valid_in may be asserted regardless of
// ready_in and the source holds data_in stable until the transfer. The output
// side has no ready: every cycle with valid_out=1 carries one pixel.
//
// Modports:
//   master - pixel source / sink side (testbench or upstream/downstream logic)
//   slave  - the up_sample block
interface up_sample_if #(
  parameter int DWIDTH = 8
);
  logic              en_upsample;
  logic [DWIDTH-1:0] data_in;
  logic              valid_in;
  logic              ready_in;
  logic [DWIDTH-1:0] data_out;
  logic              valid_out;
  logic              row_done;

  modport master (
    output en_upsample,
    output data_in,
    output valid_in,
    input  ready_in,
    input  data_out,
    input  valid_out,
    input  row_done
  );

  modport slave (
    input  en_upsample,
    input  data_in,
    input  valid_in,
    output ready_in,
    output data_out,
    output valid_out,
    output row_done
  );
endinterface

// File: rtl/up_sample.sv
// up_sample: nearest-neighbour 2x upsampler for pixel streams.
//
// A row of IN_W pooled pixels is collected into a line buffer (FILL), then
// replayed twice (EMIT_A, EMIT_B) with every pixel repeated twice, giving
// 4*IN_W contiguous output pixels per input row. With en_upsample low the
// block is a one-cycle registered pass-through.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous, active-high reset
//   bus       - up_sample_if slave modport (mode, input handshake, output)
//   dbg_state - current FSM state (0: FILL, 1: EMIT_A, 2: EMIT_B)
//
// Handshake: input transfer on an edge where valid_in && ready_in. ready_in
// is high only in FILL; during EMIT_A/EMIT_B valid_in is ignored. The output
// stream is unthrottled.
module up_sample #(
  parameter int DWIDTH = 8,
  parameter int IN_W   = 14
) (
  input  logic        clk,
  input  logic        reset,
  up_sample_if.slave  bus,
  output logic [1:0]  dbg_state
);

  // Column counter covers 0..IN_W-1; the output counter covers 0..2*IN_W-1,
  // so it is always exactly one bit wider and its upper bits index the
  // line buffer directly (each pixel shown twice).
  localparam int IW = $clog2(IN_W);
  localparam int OW = IW + 1;

  localparam logic [IW-1:0] LAST_COL = IW'(IN_W - 1);
  localparam logic [OW-1:0] LAST_OUT = OW'(2 * IN_W - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT_A = 2'd1,
    EMIT_B = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     icol, icol_nxt;
  logic [OW-1:0]     ocnt, ocnt_nxt;
  logic              mode, mode_nxt;
  logic [DWIDTH-1:0] data_out_q, data_out_nxt;
  logic              valid_out_q, valid_out_nxt;
  logic              row_done_q, row_done_nxt;

  logic [DWIDTH-1:0] line_buf [IN_W];
  logic              buf_we;
  logic              cur_mode;
  logic              accept;

  // The mode is only open to change at a row boundary (FILL, column 0).
  // At that point en_upsample itself decides how this cycle's pixel is
  // handled, so the first pixel of a row already follows the new mode; for
  // the rest of the row the latched copy is used.
  assign cur_mode = (state == FILL && icol == '0) ? bus.en_upsample : mode;

  assign bus.ready_in = (state == FILL);
  assign accept       = bus.valid_in & bus.ready_in;

  // Next-state / next-output logic
  always_comb begin
    state_nxt     = state;
    icol_nxt      = icol;
    ocnt_nxt      = ocnt;
    mode_nxt      = mode;
    data_out_nxt  = data_out_q;
    valid_out_nxt = 1'b0;
    row_done_nxt  = 1'b0;
    buf_we        = 1'b0;

    unique case (state)
      FILL: begin
        if (icol == '0) begin
          mode_nxt = bus.en_upsample;
        end
        if (!cur_mode) begin
          // Bypass: register the input straight through.
          data_out_nxt  = bus.data_in;
          valid_out_nxt = bus.valid_in;
        end else if (accept) begin
          buf_we = 1'b1;
          if (icol == LAST_COL) begin
            icol_nxt  = '0;
            state_nxt = EMIT_A;
          end else begin
            icol_nxt = icol + 1'b1;
          end
        end
      end

      EMIT_A, EMIT_B: begin
        data_out_nxt  = line_buf[ocnt[OW-1:1]];
        valid_out_nxt = 1'b1;
        if (ocnt == LAST_OUT) begin
          ocnt_nxt = '0;
          if (state == EMIT_A) begin
            state_nxt = EMIT_B;
          end else begin
            state_nxt    = FILL;
            row_done_nxt = 1'b1;
          end
        end else begin
          ocnt_nxt = ocnt + 1'b1;
        end
      end

      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      icol        <= '0;
      ocnt        <= '0;
      mode        <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      row_done_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      icol        <= icol_nxt;
      ocnt        <= ocnt_nxt;
      mode        <= mode_nxt;
      data_out_q  <= data_out_nxt;
      valid_out_q <= valid_out_nxt;
      row_done_q  <= row_done_nxt;
    end
  end

  // Line buffer: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[icol] <= bus.data_in;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.row_done  = row_done_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_up_sample.sv
// tb_up_sample: self-checking bench for up_sample with IN_W=4.
module tb_up_sample;
  localparam int DW = 8;
  localparam int IW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  up_sample_if #(.DWIDTH(DW)) bus ();

  up_sample #(.DWIDTH(DW), .IN_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // scoreboard: {row_done, data_out} expected per valid output
  logic [DW:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] pix [IW];
    int            gap;      // idle cycles between accepted pixels
    int            drop_at;  // column from which en_upsample is driven low
    int            busy;     // expected cycles with ready_in low
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present inputs for one cycle
  task automatic drive(input logic en, input logic v, input logic [DW-1:0] d);
    bus.en_upsample = en;
    bus.valid_in    = v;
    bus.data_in     = d;
    step();
  endtask

  // expected upsampled sequence: each pixel twice, whole row twice
  task automatic push_row(input logic [DW-1:0] pix [IW]);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < IW; c++)
        for (int d = 0; d < 2; d++)
          exp_q.push_back({(r == 1 && c == IW - 1 && d == 1), pix[c]});
  endtask

  task automatic run_row(input vec_t v);
    int lows;
    for (int c = 0; c < IW; c++) begin
      check("fill_ready", {31'd0, bus.ready_in}, 32'd1);
      if (c == IW - 1) push_row(v.pix);
      drive(c < v.drop_at, 1'b1, v.pix[c]);
      if (c < IW - 1)
        for (int g = 0; g < v.gap; g++) drive(c + 1 < v.drop_at, 1'b0, 8'hA5);
    end
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h5A;
    lows = 0;
    for (int i = 0; i < v.busy + 4; i++) begin
      @(negedge clk);
      if (bus.ready_in === 1'b0) lows++;
      else break;
    end
    check("busy_cycles", lows, v.busy);
    step();
    check("row_drained", exp_q.size(), 0);
  endtask

  task automatic run_bypass(input int first, input int last);
    for (int x = first; x <= last; x++) begin
      exp_q.push_back({1'b0, 8'(x)});
      drive(1'b0, 1'b1, 8'(x));
    end
    drive(1'b0, 1'b0, 8'h00);
    step();
    check("bypass_drained", exp_q.size(), 0);
  endtask

  // output monitor
  always @(negedge clk) begin : mon
    logic [DW:0] e;
    if (!reset) begin
      if (bus.valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h expected=none at %0t", bus.data_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("out", {23'd0, bus.row_done, bus.data_out}, {23'd0, e});
        end
      end else if (bus.row_done === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL row_done_no_valid actual=1 expected=0 at %0t", $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0].pix = '{8'd1, 8'd2, 8'd3, 8'd4};
    tbl[0].gap = 0; tbl[0].drop_at = IW; tbl[0].busy = 4 * IW;
    tbl[1].pix = '{8'd5, 8'd6, 8'd7, 8'd8};
    tbl[1].gap = 1; tbl[1].drop_at = IW; tbl[1].busy = 4 * IW;
    tbl[2].pix = '{8'hFF, 8'h00, 8'h80, 8'h7F};
    tbl[2].gap = 2; tbl[2].drop_at = IW; tbl[2].busy = 4 * IW;
    tbl[3].pix = '{8'd1, 8'd2, 8'd3, 8'd4};
    tbl[3].gap = 0; tbl[3].drop_at = 2; tbl[3].busy = 4 * IW;

    bus.en_upsample = 1'b0;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;

    // asynchronous reset between edges
    step();
    step();
    #2 reset = 1'b1;
    #1;
    check("rst_data_out", bus.data_out, 0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_row_done", bus.row_done, 0);
    check("rst_ready_in", bus.ready_in, 1);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 8'h00);
      check("idle_valid_out", bus.valid_out, 0);
    end

    run_bypass(1, 19);

    for (int t = 0; t < 4; t++) run_row(tbl[t]);

    // row after the mid-row mode drop is bypass
    run_bypass(20, 23);

    // reset during EMIT_A after the fifth output
    exp_q.push_back({1'b0, 8'd1});
    exp_q.push_back({1'b0, 8'd1});
    exp_q.push_back({1'b0, 8'd2});
    exp_q.push_back({1'b0, 8'd2});
    exp_q.push_back({1'b0, 8'd3});
    for (int c = 0; c < IW; c++) drive(1'b1, 1'b1, 8'(c + 1));
    bus.valid_in = 1'b0;
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid_out", bus.valid_out, 0);
    check("mid_rst_data_out", bus.data_out, 0);
    check("mid_rst_ready_in", bus.ready_in, 1);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_outputs_seen", exp_q.size(), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    step();

    begin
      vec_t v;
      v.pix = '{8'd9, 8'd10, 8'd11, 8'd12};
      v.gap = 0; v.drop_at = IW; v.busy = 4 * IW;
      run_row(v);
    end

    repeat (3) drive(1'b0, 1'b0, 8'h00);
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
